// File: rtl/vcpu_pkg.sv
// rtl/vcpu_pkg.sv - shared vcpu widths, ALU opcodes and result-slot state type
package vcpu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;
  localparam logic [2:0] ALU_OP_AND = 3'b010;
  localparam logic [2:0] ALU_OP_OR  = 3'b011;
  localparam logic [2:0] ALU_OP_XOR = 3'b100;
  localparam logic [2:0] ALU_OP_SHL = 3'b101;
  localparam logic [2:0] ALU_OP_SHR = 3'b110;
  localparam logic [2:0] ALU_OP_ILL = 3'b111;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/vcpu_alu.sv
// rtl/vcpu_alu.sv - combinational vcpu ALU; results wrap modulo 2^DW, flag_eq compares operands
module vcpu_alu
  import vcpu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int OW = OP_W
) (
  input  logic [OW-1:0] op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] c,
  output logic          flag_eq
);

  always_comb begin
    c = '0;
    case (op)
      ALU_OP_ADD: c = a + b;
      ALU_OP_SUB: c = a - b;
      ALU_OP_AND: c = a & b;
      ALU_OP_OR:  c = a | b;
      ALU_OP_XOR: c = a ^ b;
      ALU_OP_SHL: c = a << 1;
      ALU_OP_SHR: c = a >> 1;
      default:    c = '0;
    endcase
  end

  assign flag_eq = (a == b);

endmodule

// File: rtl/vcpu_rr_arb2.sv
// rtl/vcpu_rr_arb2.sv - two-way grant with a last-winner pointer that moves only on accepted transfers
module vcpu_rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // last_q holds the index of the most recently accepted requester; reset value favours req0
  logic last_q, last_d;
  logic prefer0;

  assign prefer0  = FIXED_PRIO || last_q;
  assign grant[0] = req[0] && (!req[1] || prefer0);
  assign grant[1] = req[1] && !grant[0];

  always_comb begin
    last_d = last_q;
    if (advance) last_d = grant[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/vcpu_alu_arbiter.sv
// rtl/vcpu_alu_arbiter.sv - shares one vcpu_alu between two requesters through a single registered result slot
module vcpu_alu_arbiter #(
  parameter int DATA_W     = vcpu_pkg::DATA_W,
  parameter int OP_W       = vcpu_pkg::OP_W,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_c,
  output logic              rsp_eq,
  output logic              rsp_err
);

  import vcpu_pkg::*;

  slot_state_e       state_q, state_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic              eq_q, eq_d;
  logic              err_q, err_d;

  logic [1:0]        grant;
  logic              drain, can_accept, accept;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_c;
  logic              alu_eq, op_ill;

  vcpu_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign alu_op = grant[1] ? req1_op : req0_op;
  assign alu_a  = grant[1] ? req1_a  : req0_a;
  assign alu_b  = grant[1] ? req1_b  : req0_b;

  vcpu_alu #(.DW(DATA_W), .OW(OP_W)) u_alu (
    .op      (alu_op),
    .a       (alu_a),
    .b       (alu_b),
    .c       (alu_c),
    .flag_eq (alu_eq)
  );

  assign op_ill = (alu_op == ALU_OP_ILL);

  // A draining slot can take the next operation on the same edge, so there is no bubble
  assign drain      = (state_q == SLOT_FULL) && rsp_ready[owner_q];
  assign can_accept = (state_q == SLOT_EMPTY) || drain;
  assign req_ready  = can_accept ? (grant & req_valid) : 2'b00;
  assign accept     = |req_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    c_d     = c_q;
    eq_d    = eq_q;
    err_d   = err_q;
    if (accept) begin
      state_d = SLOT_FULL;
      owner_d = grant[1];
      c_d     = op_ill ? '0 : alu_c;
      eq_d    = !op_ill && alu_eq;
      err_d   = op_ill;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      owner_q <= 1'b0;
      c_q     <= '0;
      eq_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      c_q     <= c_d;
      eq_q    <= eq_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == SLOT_FULL) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_c     = c_q;
  assign rsp_eq    = eq_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_vcpu_alu_arbiter.sv
// tb/tb_vcpu_alu_arbiter.sv - bench for vcpu_alu_arbiter: instance 0 round-robin, instance 1 fixed priority
module tb_vcpu_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid [2];
  logic [1:0] req_ready [2];
  logic [1:0] rsp_valid [2];
  logic [1:0] rsp_ready [2];
  logic [2:0] op_i [2][2];
  logic [7:0] a_i  [2][2];
  logic [7:0] b_i  [2][2];
  logic [7:0] rsp_c   [2];
  logic       rsp_eq  [2];
  logic       rsp_err [2];

  int checks = 0;
  int errors = 0;
  string phase = "init";

  int         m_full  [2];
  int         m_owner [2];
  int         m_last  [2];
  int         m_win   [2];
  logic [7:0] m_c     [2];
  logic       m_eq    [2];
  logic       m_err   [2];
  logic [1:0] m_rdy   [2];
  bit         hold    [2][2];

  always #5 clk = ~clk;

  vcpu_alu_arbiter #(.DATA_W(8), .OP_W(3), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req0_op(op_i[0][0]), .req0_a(a_i[0][0]), .req0_b(b_i[0][0]),
    .req1_op(op_i[0][1]), .req1_a(a_i[0][1]), .req1_b(b_i[0][1]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_c(rsp_c[0]), .rsp_eq(rsp_eq[0]), .rsp_err(rsp_err[0])
  );

  vcpu_alu_arbiter #(.DATA_W(8), .OP_W(3), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req0_op(op_i[1][0]), .req0_a(a_i[1][0]), .req0_b(b_i[1][0]),
    .req1_op(op_i[1][1]), .req1_a(a_i[1][1]), .req1_b(b_i[1][1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_c(rsp_c[1]), .rsp_eq(rsp_eq[1]), .rsp_err(rsp_err[1])
  );

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int x = int'(a);
    int y = int'(b);
    int r;
    case (op)
      3'd0:    r = x + y;
      3'd1:    r = x - y;
      3'd2:    r = x & y;
      3'd3:    r = x | y;
      3'd4:    r = x ^ y;
      3'd5:    r = x * 2;
      3'd6:    r = x / 2;
      default: r = 0;
    endcase
    r = ((r % 256) + 256) % 256;
    return 8'(r);
  endfunction

  // -1 = nobody requests; instance 1 is the fixed-priority one
  function automatic int winner(input int m);
    bit v0 = req_valid[m][0];
    bit v1 = req_valid[m][1];
    if (!v0 && !v1) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (m == 1) return 0;
    return (m_last[m] == 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_full[m]  = 0;
      m_owner[m] = 0;
      m_last[m]  = 1;
      m_c[m]     = 8'd0;
      m_eq[m]    = 1'b0;
      m_err[m]   = 1'b0;
      hold[m][0] = 1'b0;
      hold[m][1] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s rsp_valid[%0d]", phase, m), 8'(rsp_valid[m]),
            (m_full[m] == 0) ? 8'd0 : ((m_owner[m] == 1) ? 8'd2 : 8'd1));
      check($sformatf("%s rsp_c[%0d]", phase, m), rsp_c[m], m_c[m]);
      check($sformatf("%s rsp_eq[%0d]", phase, m), 8'(rsp_eq[m]), 8'(m_eq[m]));
      check($sformatf("%s rsp_err[%0d]", phase, m), 8'(rsp_err[m]), 8'(m_err[m]));
    end
  endtask

  task automatic drive(input int m, input int i, input bit v, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    req_valid[m][i] = v;
    op_i[m][i] = op;
    a_i[m][i]  = a;
    b_i[m][i]  = b;
  endtask

  task automatic idle_all();
    for (int m = 0; m < 2; m++) begin
      drive(m, 0, 1'b0, 3'd0, 8'd0, 8'd0);
      drive(m, 1, 1'b0, 3'd0, 8'd0, 8'd0);
      rsp_ready[m] = 2'b00;
    end
  endtask

  // Called at posedge+1 with inputs already driven; ends at the next posedge+1
  task automatic step();
    for (int m = 0; m < 2; m++) begin
      m_win[m] = winner(m);
      if (m_win[m] >= 0 && (m_full[m] == 0 || rsp_ready[m][m_owner[m]]))
        m_rdy[m] = (m_win[m] == 1) ? 2'b10 : 2'b01;
      else
        m_rdy[m] = 2'b00;
    end
    #1;
    for (int m = 0; m < 2; m++)
      check($sformatf("%s req_ready[%0d]", phase, m), 8'(req_ready[m]), 8'(m_rdy[m]));
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (m_rdy[m] != 2'b00) begin
        int w = m_win[m];
        m_full[m]  = 1;
        m_owner[m] = w;
        m_last[m]  = w;
        m_err[m]   = (op_i[m][w] == 3'd7);
        m_c[m]     = m_err[m] ? 8'd0 : alu_ref(op_i[m][w], a_i[m][w], b_i[m][w]);
        m_eq[m]    = !m_err[m] && (a_i[m][w] == b_i[m][w]);
      end else if (m_full[m] == 1 && rsp_ready[m][m_owner[m]]) begin
        m_full[m] = 0;
      end
      for (int i = 0; i < 2; i++)
        hold[m][i] = req_valid[m][i] && !m_rdy[m][i];
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle_all();
    @(posedge clk);
    #1;
    phase = "reset";
    do_reset();
    step();

    phase = "t2_add";
    drive(0, 0, 1'b1, 3'd0, 8'd23, 8'd44);
    rsp_ready[0] = 2'b01;
    step();
    check("t2 rsp_c=67", rsp_c[0], 8'd67);
    drive(0, 0, 1'b0, 3'd0, 8'd0, 8'd0);
    step();

    phase = "t1_reset_full";
    drive(0, 0, 1'b1, 3'd0, 8'd1, 8'd2);
    rsp_ready[0] = 2'b00;
    step();
    idle_all();
    do_reset();
    step();
    step();

    phase = "t3_rr";
    drive(0, 0, 1'b1, 3'd0, 8'd10, 8'd20);
    drive(0, 1, 1'b1, 3'd1, 8'd44, 8'd23);
    rsp_ready[0] = 2'b11;
    step();
    check("t3 first grant req0", 8'(rsp_valid[0]), 8'd1);
    step();
    check("t3 sub rsp_c=21", rsp_c[0], 8'd21);
    step();
    step();
    check("t3 fourth grant req1", 8'(rsp_valid[0]), 8'd2);
    drive(0, 0, 1'b0, 3'd0, 8'd0, 8'd0);
    drive(0, 1, 1'b0, 3'd0, 8'd0, 8'd0);
    step();

    phase = "t4_stall";
    drive(0, 0, 1'b1, 3'd0, 8'd5, 8'd6);
    rsp_ready[0] = 2'b00;
    step();
    drive(0, 0, 1'b1, 3'd0, 8'd7, 8'd8);
    rsp_ready[0] = 2'b10;
    for (int k = 0; k < 3; k++) step();
    check("t4 held rsp_c=11", rsp_c[0], 8'd11);
    rsp_ready[0] = 2'b01;
    step();
    check("t4 reload rsp_c=15", rsp_c[0], 8'd15);
    drive(0, 0, 1'b0, 3'd0, 8'd0, 8'd0);
    step();

    phase = "t5_wrap_eq";
    drive(0, 0, 1'b1, 3'd0, 8'd200, 8'd100);
    step();
    check("t5 wrap rsp_c=44", rsp_c[0], 8'd44);
    drive(0, 0, 1'b1, 3'd4, 8'd23, 8'd23);
    step();
    check("t5 rsp_eq=1", 8'(rsp_eq[0]), 8'd1);
    drive(0, 0, 1'b0, 3'd0, 8'd0, 8'd0);
    rsp_ready[0] = 2'b11;
    step();

    phase = "t6_illegal";
    drive(0, 1, 1'b1, 3'd7, 8'd9, 8'd9);
    step();
    check("t6 rsp_err=1", 8'(rsp_err[0]), 8'd1);
    drive(0, 1, 1'b1, 3'd0, 8'd1, 8'd1);
    step();
    check("t6 rsp_err cleared", 8'(rsp_err[0]), 8'd0);
    drive(0, 1, 1'b0, 3'd0, 8'd0, 8'd0);
    step();

    phase = "t6_fixed_prio";
    drive(1, 0, 1'b1, 3'd0, 8'd3, 8'd4);
    drive(1, 1, 1'b1, 3'd1, 8'd9, 8'd2);
    rsp_ready[1] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      check("fp req1 starved", 8'(rsp_valid[1]), 8'd1);
    end
    drive(1, 0, 1'b0, 3'd0, 8'd0, 8'd0);
    step();
    check("fp req1 served", 8'(rsp_valid[1]), 8'd2);
    idle_all();
    rsp_ready[0] = 2'b11;
    rsp_ready[1] = 2'b11;
    step();

    phase = "random";
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < 2; i++) begin
          if (!hold[m][i]) begin
            logic [7:0] ra = 8'($urandom_range(0, 255));
            logic [7:0] rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
            drive(m, i, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ra, rb);
          end
        end
        rsp_ready[m] = 2'($urandom_range(0, 3));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
